// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-bit 2-FF sync, counter debounce, press/release pulses.
// Optional toggle_o flops built only when BUTTON_CONDITIONER_TOGGLE_EN is defined.
module button_conditioner #(
    parameter int width_p         = 3,
    parameter int stable_cycles_p = 60000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] button_i,
    output logic [width_p-1:0] state_o,
    output logic [width_p-1:0] press_o,
    output logic [width_p-1:0] release_o,
    output logic [width_p-1:0] toggle_o
);

    localparam int cnt_w_lp = $clog2(stable_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(stable_cycles_p - 1);

    logic [width_p-1:0] s0;
    logic [width_p-1:0] s1;
    logic [cnt_w_lp-1:0] cnt [width_p];
    logic [width_p-1:0] state_r;
    logic [width_p-1:0] press_r;
    logic [width_p-1:0] release_r;
    logic [width_p-1:0] flip;

    // A channel flips on the last of stable_cycles_p consecutive disagreeing samples.
    always_comb begin
        flip = '0;
        for (int k = 0; k < width_p; k++) begin
            flip[k] = (s1[k] != state_r[k]) && (cnt[k] == cnt_last_lp);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s0        <= '0;
            s1        <= '0;
            state_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int k = 0; k < width_p; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            s0        <= button_i;
            s1        <= s0;
            state_r   <= state_r ^ flip;
            press_r   <= flip & s1;
            release_r <= flip & ~s1;
            for (int k = 0; k < width_p; k++) begin
                if (s1[k] == state_r[k] || flip[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign state_o   = state_r;
    assign press_o   = press_r;
    assign release_o = release_r;

`ifdef BUTTON_CONDITIONER_TOGGLE_EN
    logic [width_p-1:0] toggle_r;

    // Inverts on the same edge that raises press_o, so both appear together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            toggle_r <= '0;
        end else begin
            toggle_r <= toggle_r ^ (flip & s1);
        end
    end

    assign toggle_o = toggle_r;
`else
    assign toggle_o = '0;
`endif

endmodule
